// File: rtl/loss_pkg.sv
// Types shared by the node and loss blocks: the default operand and product
// types and the loss sequencing states.
package loss_pkg;

  localparam int unsigned OPERAND_W = 8;

  typedef logic signed [OPERAND_W-1:0]   operand_t;
  typedef logic signed [2*OPERAND_W-1:0] product_t;

  typedef enum logic [2:0] {
    LOAD,
    DIFF,
    ACC,
    ERR,
    COST
  } state_t;

endpackage

// File: rtl/loss_sat_accumulator.sv
// Unsigned accumulator that clamps at the largest positive signed value of
// its width. o_next is the value the register takes at the next edge when
// enabled, so a consumer can capture the final sum in the same cycle that a
// clear is applied.
module sat_accumulator #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_addend,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_next
);

  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

  logic [WIDTH-1:0] r_sum;
  logic [WIDTH:0]   w_wide;

  assign w_wide = {1'b0, r_sum} + {1'b0, i_addend};

  // Saturated next value; holds the current sum while not enabled
  always_comb begin
    o_next = r_sum;
    if (i_enable) begin
      o_next = (w_wide > {1'b0, MAX_VAL}) ? MAX_VAL : w_wide[WIDTH-1:0];
    end
  end

  // Sum register; clear wins over enable
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_sum <= '0;
    end else if (i_enable) begin
      r_sum <= o_next;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/loss.sv
// Squared-error loss stage. Collects one activation and one target, forms
// the signed error, accumulates (error^2 >>> (WIDTH-1)) over a batch, returns
// the error to the node when training and reports the batch cost at the end
// of every BATCH samples.
module loss
  import loss_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BATCH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 train,
  input  logic                 activation_valid,
  input  logic [WIDTH-1:0]     activation_data,
  output logic                 activation_ready,
  input  logic                 target_valid,
  input  logic [WIDTH-1:0]     target_data,
  output logic                 target_ready,
  output logic                 error_valid,
  output logic [2*WIDTH-1:0]   error_data,
  input  logic                 error_ready,
  output logic                 cost_valid,
  output logic [2*WIDTH-1:0]   cost_data,
  input  logic                 cost_ready
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (BATCH > 2) ? $clog2(BATCH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BATCH - 1);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]       r_act;
  logic [WIDTH-1:0]       r_tgt;
  logic                   r_act_held;
  logic                   r_tgt_held;
  logic                   r_train;
  logic                   r_last;
  logic [CW-1:0]          r_count;
  logic signed [PW-1:0]   r_error;
  logic [PW-1:0]          r_cost;

  logic                   w_act_fire;
  logic                   w_tgt_fire;
  logic                   w_to_diff;
  logic                   w_enter_cost;
  logic signed [2*PW-1:0] w_err_ext;
  logic [PW-1:0]          w_addend;
  logic [PW-1:0]          w_acc_sum;
  logic [PW-1:0]          w_acc_next;

  // Next-state and handshake outputs
  always_comb begin
    w_next           = r_state;
    activation_ready = 1'b0;
    target_ready     = 1'b0;
    error_valid      = 1'b0;
    cost_valid       = 1'b0;
    unique case (r_state)
      LOAD: begin
        activation_ready = !r_act_held;
        target_ready     = !r_tgt_held;
        if (r_act_held && r_tgt_held) begin
          w_next = DIFF;
        end
      end
      DIFF: w_next = ACC;
      ACC: begin
        if (r_train) begin
          w_next = ERR;
        end else if (r_count == LAST_IDX) begin
          w_next = COST;
        end else begin
          w_next = LOAD;
        end
      end
      ERR: begin
        error_valid = 1'b1;
        if (error_ready) begin
          w_next = r_last ? COST : LOAD;
        end
      end
      COST: begin
        cost_valid = 1'b1;
        if (cost_ready) begin
          w_next = LOAD;
        end
      end
      default: w_next = LOAD;
    endcase
  end

  assign w_act_fire   = activation_valid && activation_ready;
  assign w_tgt_fire   = target_valid && target_ready;
  assign w_to_diff    = (r_state == LOAD) && (w_next == DIFF);
  assign w_enter_cost = (w_next == COST) && (r_state != COST);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // Independent operand capture; held flags drop when the pair moves on
  always_ff @(posedge clock) begin
    if (reset) begin
      r_act_held <= 1'b0;
      r_tgt_held <= 1'b0;
    end else if (w_to_diff) begin
      r_act_held <= 1'b0;
      r_tgt_held <= 1'b0;
    end else begin
      if (w_act_fire) begin
        r_act      <= activation_data;
        r_act_held <= 1'b1;
      end
      if (w_tgt_fire) begin
        r_tgt      <= target_data;
        r_tgt_held <= 1'b1;
      end
    end
  end

  // Exact signed error and the train decision for this sample
  always_ff @(posedge clock) begin
    if (r_state == DIFF) begin
      r_error <= {{WIDTH{r_tgt[WIDTH-1]}}, r_tgt} - {{WIDTH{r_act[WIDTH-1]}}, r_act};
      r_train <= train;
    end
  end

  // Sample counter; r_last remembers the batch end past the wrap for ERR
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
      r_last  <= 1'b0;
    end else if (r_state == ACC) begin
      r_count <= (r_count == LAST_IDX) ? '0 : r_count + CW'(1);
      r_last  <= (r_count == LAST_IDX);
    end
  end

  assign w_err_ext = {{PW{r_error[PW-1]}}, r_error};
  assign w_addend  = PW'((w_err_ext * w_err_ext) >>> (WIDTH - 1));

  // The clear on COST entry may coincide with the final add; the report takes
  // the post-add value so that sample is not lost.
  sat_accumulator #(
    .WIDTH(PW)
  ) u_acc (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_enter_cost),
    .i_enable(r_state == ACC),
    .i_addend(w_addend),
    .o_sum   (w_acc_sum),
    .o_next  (w_acc_next)
  );

  // Batch cost capture on entry to COST
  always_ff @(posedge clock) begin
    if (w_enter_cost) begin
      r_cost <= (r_state == ACC) ? w_acc_next : w_acc_sum;
    end
  end

  assign error_data = r_error;
  assign cost_data  = r_cost;

endmodule

// File: tb/tb_loss.sv
// Bench for loss: a BATCH=4 instance for most scenarios and a BATCH=128
// instance for saturation, both driven through one muxed set of signals.
module tb_loss;

  localparam int W   = 8;
  localparam int SAT = 32767;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic train = 1'b0;
  logic sel   = 1'b0;
  logic activation_valid = 1'b0;
  logic target_valid     = 1'b0;
  logic error_ready      = 1'b0;
  logic cost_ready       = 1'b0;
  logic [7:0] activation_data = '0;
  logic [7:0] target_data     = '0;

  logic activation_ready, target_ready, error_valid, cost_valid;
  logic [15:0] error_data, cost_data;

  logic s_ar, s_tr, s_ev, s_cv, b_ar, b_tr, b_ev, b_cv;
  logic [15:0] s_ed, s_cd, b_ed, b_cd;

  int total = 0;
  int bad   = 0;
  int m_acc = 0;
  int m_cnt = 0;
  int m_batch = 4;

  always #5 clock = ~clock;

  assign activation_ready = sel ? b_ar : s_ar;
  assign target_ready     = sel ? b_tr : s_tr;
  assign error_valid      = sel ? b_ev : s_ev;
  assign cost_valid       = sel ? b_cv : s_cv;
  assign error_data       = sel ? b_ed : s_ed;
  assign cost_data        = sel ? b_cd : s_cd;

  loss #(.WIDTH(8), .BATCH(4)) u_dut (
    .clock(clock), .reset(reset), .train(train),
    .activation_valid(activation_valid & ~sel), .activation_data(activation_data),
    .activation_ready(s_ar),
    .target_valid(target_valid & ~sel), .target_data(target_data), .target_ready(s_tr),
    .error_valid(s_ev), .error_data(s_ed), .error_ready(error_ready & ~sel),
    .cost_valid(s_cv), .cost_data(s_cd), .cost_ready(cost_ready & ~sel)
  );

  loss #(.WIDTH(8), .BATCH(128)) u_big (
    .clock(clock), .reset(reset), .train(train),
    .activation_valid(activation_valid & sel), .activation_data(activation_data),
    .activation_ready(b_ar),
    .target_valid(target_valid & sel), .target_data(target_data), .target_ready(b_tr),
    .error_valid(b_ev), .error_data(b_ed), .error_ready(error_ready & sel),
    .cost_valid(b_cv), .cost_data(b_cd), .cost_ready(cost_ready & sel)
  );

  // Reference: error is target minus activation, cost sums floor(err^2 / 2^(W-1))
  // clamped to SAT, reported and restarted every m_batch samples.
  task automatic model_step(input int t, input int a, output int err,
                            output bit last, output int cost);
    err   = t - a;
    m_acc = m_acc + (err * err) / (2 ** (W - 1));
    if (m_acc > SAT) m_acc = SAT;
    m_cnt = m_cnt + 1;
    last  = (m_cnt == m_batch);
    cost  = m_acc;
    if (last) begin
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    activation_valid = 1'b0;
    target_valid = 1'b0;
    error_ready = 1'b0;
    cost_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    m_acc = 0;
    m_cnt = 0;
  endtask

  // Present target, and activation `gap` cycles later; bounded wait.
  task automatic feed(input int t, input int a, input int gap);
    bit t_done, a_done, t_fire, a_fire;
    int cyc;
    t_done = 0;
    a_done = 0;
    cyc = 0;
    target_data = 8'(t);
    activation_data = 8'(a);
    while (!(t_done && a_done) && cyc < 40) begin
      @(negedge clock);
      target_valid = !t_done;
      activation_valid = !a_done && (cyc >= gap);
      t_fire = target_valid && target_ready;
      a_fire = activation_valid && activation_ready;
      @(posedge clock);
      #1;
      if (t_fire) t_done = 1;
      if (a_fire) a_done = 1;
      target_valid = 1'b0;
      activation_valid = 1'b0;
      cyc++;
    end
    if (!(t_done && a_done)) begin
      total++;
      bad++;
      $display("FAIL feed_timeout: target_taken=%0b activation_taken=%0b required 1 1",
               t_done, a_done);
    end
  endtask

  // Let the sample run through DIFF/ACC and acknowledge whatever it reports.
  task automatic drain(output bit saw_err, output logic [15:0] e,
                       output bit saw_cost, output logic [15:0] c);
    saw_err = 0;
    saw_cost = 0;
    e = '0;
    c = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    if (error_valid) begin
      saw_err = 1;
      e = error_data;
      error_ready = 1'b1;
      @(posedge clock);
      #1 error_ready = 1'b0;
      @(negedge clock);
    end
    if (cost_valid) begin
      saw_cost = 1;
      c = cost_data;
      cost_ready = 1'b1;
      @(posedge clock);
      #1 cost_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    total++; if (activation_ready !== 1'b1) begin bad++; $display("FAIL reset_act_ready: got %b want 1", activation_ready); end
    total++; if (target_ready !== 1'b1) begin bad++; $display("FAIL reset_tgt_ready: got %b want 1", target_ready); end
    total++; if (error_valid !== 1'b0) begin bad++; $display("FAIL reset_error_valid: got %b want 0", error_valid); end
    total++; if (cost_valid !== 1'b0) begin bad++; $display("FAIL reset_cost_valid: got %b want 0", cost_valid); end
  endtask

  task automatic test_vectors();
    int ts[4] = '{127, 0, 5, -3};
    int as[4] = '{63, 127, 5, -3};
    bit trs[4] = '{1, 1, 0, 0};
    bit se, sc, last;
    logic [15:0] e, c;
    int err, cost;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      train = trs[i];
      feed(ts[i], as[i], 0);
      drain(se, e, sc, c);
      model_step(ts[i], as[i], err, last, cost);
      total++; if (se !== trs[i]) begin bad++; $display("FAIL vec_err_valid[%0d]: got %b want %b", i, se, trs[i]); end
      if (trs[i]) begin
        total++; if (e !== 16'(err)) begin bad++; $display("FAIL vec_err_data[%0d]: got %h want %h", i, e, 16'(err)); end
      end
      total++; if (sc !== last) begin bad++; $display("FAIL vec_cost_valid[%0d]: got %b want %b", i, sc, last); end
      if (last) begin
        total++; if (c !== 16'(cost)) begin bad++; $display("FAIL vec_cost_data: got %0d want %0d", c, cost); end
      end
    end
    total++; if (cost !== 158) begin bad++; $display("FAIL vec_model_cost: got %0d want 158", cost); end
  endtask

  task automatic test_batch();
    int ts[8] = '{64, 100, -1, 127, 100, 50, -28, 0};
    int as[8] = '{0, 36, -65, 63, 0, -50, -128, -100};
    int want[2] = '{128, 312};
    bit se, sc;
    logic [15:0] e, c;
    do_reset();
    train = 1'b0;
    for (int i = 0; i < 8; i++) begin
      feed(ts[i], as[i], i % 3);
      drain(se, e, sc, c);
      total++; if (se !== 1'b0) begin bad++; $display("FAIL batch_no_err[%0d]: got %b want 0", i, se); end
      total++; if (sc !== (i % 4 == 3)) begin bad++; $display("FAIL batch_cost_valid[%0d]: got %b want %b", i, sc, (i % 4 == 3)); end
      if (i % 4 == 3) begin
        total++; if (c !== 16'(want[i / 4])) begin bad++; $display("FAIL batch_cost[%0d]: got %0d want %0d", i / 4, c, want[i / 4]); end
      end
    end
  endtask

  task automatic test_stall();
    int exp_err;
    do_reset();
    train = 1'b1;
    feed(-20, 30, 3);
    exp_err = -50;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      total++; if (error_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", k, error_valid); end
      total++; if (error_data !== 16'(exp_err)) begin bad++; $display("FAIL stall_data[%0d]: got %h want %h", k, error_data, 16'(exp_err)); end
      total++; if ({activation_ready, target_ready} !== 2'b00) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 00", k, {activation_ready, target_ready}); end
      @(negedge clock);
    end
    error_ready = 1'b1;
    @(posedge clock);
    #1 error_ready = 1'b0;
    @(negedge clock);
    total++; if ({error_valid, activation_ready, target_ready} !== 3'b011) begin bad++; $display("FAIL stall_release: got %b want 011", {error_valid, activation_ready, target_ready}); end
  endtask

  task automatic test_random();
    bit se, sc, last, tr;
    logic [15:0] e, c;
    int t, a, err, cost;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      t = int'($urandom_range(255)) - 128;
      a = int'($urandom_range(255)) - 128;
      tr = 1'($urandom_range(1));
      train = tr;
      feed(t, a, int'($urandom_range(2)));
      drain(se, e, sc, c);
      model_step(t, a, err, last, cost);
      total++; if (se !== tr) begin bad++; $display("FAIL rnd_err_valid[%0d]: got %b want %b", i, se, tr); end
      if (tr) begin
        total++; if (e !== 16'(err)) begin bad++; $display("FAIL rnd_err_data[%0d]: got %h want %h", i, e, 16'(err)); end
      end
      total++; if (sc !== last) begin bad++; $display("FAIL rnd_cost_valid[%0d]: got %b want %b", i, sc, last); end
      if (last) begin
        total++; if (c !== 16'(cost)) begin bad++; $display("FAIL rnd_cost[%0d]: got %0d want %0d", i, c, cost); end
      end
    end
  endtask

  task automatic test_saturation();
    bit se, sc;
    logic [15:0] e, c;
    int acc;
    do_reset();
    sel = 1'b1;
    train = 1'b0;
    acc = 0;
    for (int i = 0; i < 128; i++) begin
      if (i < 70) begin
        feed(127, -128, 0);
        acc = acc + 508;
      end else begin
        feed(9, 9, 0);
      end
      if (acc > SAT) acc = SAT;
      drain(se, e, sc, c);
      total++; if (sc !== (i == 127)) begin bad++; $display("FAIL sat_cost_valid[%0d]: got %b want %b", i, sc, (i == 127)); end
      if (i == 127) begin
        total++; if (c !== 16'(acc)) begin bad++; $display("FAIL sat_cost: got %h want %h", c, 16'(acc)); end
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit se, sc, last;
    logic [15:0] e, c;
    int t, a, err, cost;
    do_reset();
    train = 1'b1;
    feed(10, 20, 0);
    drain(se, e, sc, c);
    feed(-50, 40, 1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++; if (error_valid !== 1'b1) begin bad++; $display("FAIL rmid_in_err: got %b want 1", error_valid); end
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    @(negedge clock);
    total++; if ({error_valid, cost_valid} !== 2'b00) begin bad++; $display("FAIL rmid_valids: got %b want 00", {error_valid, cost_valid}); end
    total++; if ({activation_ready, target_ready} !== 2'b11) begin bad++; $display("FAIL rmid_readies: got %b want 11", {activation_ready, target_ready}); end
    target_valid = 1'b1;
    target_data = 8'd77;
    @(posedge clock);
    #1 target_valid = 1'b0;
    @(negedge clock);
    total++; if (target_ready !== 1'b0) begin bad++; $display("FAIL rmid_tgt_held: got %b want 0", target_ready); end
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    train = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = int'($urandom_range(255)) - 128;
      a = int'($urandom_range(255)) - 128;
      feed(t, a, (i == 0) ? 2 : 0);
      drain(se, e, sc, c);
      model_step(t, a, err, last, cost);
      total++; if (sc !== last) begin bad++; $display("FAIL rmid_cost_valid[%0d]: got %b want %b", i, sc, last); end
      if (last) begin
        total++; if (c !== 16'(cost)) begin bad++; $display("FAIL rmid_cost: got %0d want %0d", c, cost); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_batch();
    test_stall();
    test_random();
    test_saturation();
    m_batch = 4;
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
